// File: rtl/count_date_pkg.sv
// clock_pkg: shared definitions for the digital-clock date stage.
//   - field widths for day / month / year counters
//   - month number constants
//   - non-leap month lengths
//   - is_leap(): leap test valid for years 2000-2099 (yr = offset from 2000)
package clock_pkg;

  localparam int DAY_W = 5;
  localparam int MON_W = 4;
  localparam int YR_W  = 7;

  localparam logic [MON_W-1:0] MON_JAN = 4'd1;
  localparam logic [MON_W-1:0] MON_FEB = 4'd2;
  localparam logic [MON_W-1:0] MON_MAR = 4'd3;
  localparam logic [MON_W-1:0] MON_APR = 4'd4;
  localparam logic [MON_W-1:0] MON_MAY = 4'd5;
  localparam logic [MON_W-1:0] MON_JUN = 4'd6;
  localparam logic [MON_W-1:0] MON_JUL = 4'd7;
  localparam logic [MON_W-1:0] MON_AUG = 4'd8;
  localparam logic [MON_W-1:0] MON_SEP = 4'd9;
  localparam logic [MON_W-1:0] MON_OCT = 4'd10;
  localparam logic [MON_W-1:0] MON_NOV = 4'd11;
  localparam logic [MON_W-1:0] MON_DEC = 4'd12;

  // Index 0 = January. February holds the non-leap length.
  localparam logic [DAY_W-1:0] MON_LEN [12] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  // Within 2000-2099 every year divisible by 4 is a leap year (2000 included).
  function automatic logic is_leap(input logic [YR_W-1:0] yr);
    return (yr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/count_date_if.sv
// count_date_if: day-carry input, date outputs and month/year carries of the
// calendar stage.
//   master : upstream/downstream side (drives pulse_d, reads the date)
//   slave  : count_date itself
// With COUNT_DATE_LOAD_EN defined the interface also carries the load port
// (ld_en, ld_day, ld_mon, ld_yr).
interface count_date_if;
  import clock_pkg::*;

  logic             pulse_d;
  logic [DAY_W-1:0] cnt_day;
  logic [MON_W-1:0] cnt_mon;
  logic [YR_W-1:0]  cnt_yr;
  logic             pulse_m;
  logic             pulse_y;
`ifdef COUNT_DATE_LOAD_EN
  logic             ld_en;
  logic [DAY_W-1:0] ld_day;
  logic [MON_W-1:0] ld_mon;
  logic [YR_W-1:0]  ld_yr;
`endif

  modport master (
    output pulse_d,
`ifdef COUNT_DATE_LOAD_EN
    output ld_en, ld_day, ld_mon, ld_yr,
`endif
    input  cnt_day, cnt_mon, cnt_yr, pulse_m, pulse_y
  );

  modport slave (
    input  pulse_d,
`ifdef COUNT_DATE_LOAD_EN
    input  ld_en, ld_day, ld_mon, ld_yr,
`endif
    output cnt_day, cnt_mon, cnt_yr, pulse_m, pulse_y
  );

endinterface

// File: rtl/count_date_days_in_month.sv
// days_in_month: combinational month-length lookup.
//   mon : month 1-12 (anything else yields 31, which never matters because
//         the caller treats an illegal month separately)
//   yr  : year offset from 2000, used for the February leap adjustment
//   dim : number of days in that month
module days_in_month
  import clock_pkg::*;
(
  input  logic [MON_W-1:0] mon,
  input  logic [YR_W-1:0]  yr,
  output logic [DAY_W-1:0] dim
);

  logic [MON_W-1:0] idx;

  always_comb begin
    idx = mon - MON_JAN;
    dim = 5'd31;
    if (mon >= MON_JAN && mon <= MON_DEC) begin
      dim = MON_LEN[idx];
      if (mon == MON_FEB && is_leap(yr)) begin
        dim = 5'd29;
      end
    end
  end

endmodule

// File: rtl/count_date.sv
// count_date: day / month / year calendar stage (years 2000-2099).
//   clk     : system clock, rising edge
//   set_d   : synchronous active-high reset -> Jan 1, year YEAR_INIT
//   bus     : count_date_if.slave
//             pulse_d  - day carry, one increment per high cycle
//             cnt_day  - day of month 1-31
//             cnt_mon  - month 1-12
//             cnt_yr   - year offset from 2000, 0..YEAR_MAX
//             pulse_m  - registered month carry (day rolled to 1)
//             pulse_y  - registered year carry (Dec 31 -> Jan 1)
// Optional build macro COUNT_DATE_LOAD_EN adds a validated date load
// (ld_en/ld_day/ld_mon/ld_yr); priority set_d > ld_en > pulse_d.
module count_date
  import clock_pkg::*;
#(
  parameter int YEAR_INIT = 24,
  parameter int YEAR_MAX  = 99
) (
  input  logic clk,
  input  logic set_d,
  count_date_if.slave bus
);

  localparam logic [YR_W-1:0] YR_INIT_L = YR_W'(YEAR_INIT);
  localparam logic [YR_W-1:0] YR_MAX_L  = YR_W'(YEAR_MAX);

  logic [DAY_W-1:0] day_reg, day_next;
  logic [MON_W-1:0] mon_reg, mon_next;
  logic [YR_W-1:0]  yr_reg,  yr_next;
  logic             pm_reg,  pm_next;
  logic             py_reg,  py_next;

  logic [DAY_W-1:0] dim_cur;
  logic             mon_ok;

  days_in_month u_dim_cur (
    .mon (mon_reg),
    .yr  (yr_reg),
    .dim (dim_cur)
  );

`ifdef COUNT_DATE_LOAD_EN
  logic [DAY_W-1:0] dim_ld;
  logic             ld_ok;
  logic [DAY_W-1:0] ld_day_fix;

  days_in_month u_dim_ld (
    .mon (bus.ld_mon),
    .yr  (bus.ld_yr),
    .dim (dim_ld)
  );

  always_comb begin
    ld_ok = (bus.ld_mon >= MON_JAN) && (bus.ld_mon <= MON_DEC) &&
            (bus.ld_yr <= YR_MAX_L);
    if (bus.ld_day == '0) begin
      ld_day_fix = DAY_W'(1);
    end else if (bus.ld_day > dim_ld) begin
      ld_day_fix = dim_ld;
    end else begin
      ld_day_fix = bus.ld_day;
    end
  end
`endif

  assign mon_ok = (mon_reg >= MON_JAN) && (mon_reg <= MON_DEC);

  always_comb begin
    day_next = day_reg;
    mon_next = mon_reg;
    yr_next  = yr_reg;
    pm_next  = 1'b0;
    py_next  = 1'b0;
`ifdef COUNT_DATE_LOAD_EN
    if (bus.ld_en) begin
      // A rejected load still swallows a coincident day pulse.
      if (ld_ok) begin
        day_next = ld_day_fix;
        mon_next = bus.ld_mon;
        yr_next  = bus.ld_yr;
      end
    end else
`endif
    if (bus.pulse_d) begin
      if (mon_ok && day_reg < dim_cur) begin
        day_next = day_reg + DAY_W'(1);
      end else begin
        // Month rollover; also the recovery path for day > dim or bad month.
        day_next = DAY_W'(1);
        pm_next  = 1'b1;
        if (!mon_ok) begin
          mon_next = MON_JAN;
        end else if (mon_reg == MON_DEC) begin
          mon_next = MON_JAN;
          py_next  = 1'b1;
          yr_next  = (yr_reg >= YR_MAX_L) ? '0 : yr_reg + YR_W'(1);
        end else begin
          mon_next = mon_reg + MON_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (set_d) begin
      day_reg <= DAY_W'(1);
      mon_reg <= MON_JAN;
      yr_reg  <= YR_INIT_L;
      pm_reg  <= 1'b0;
      py_reg  <= 1'b0;
    end else begin
      day_reg <= day_next;
      mon_reg <= mon_next;
      yr_reg  <= yr_next;
      pm_reg  <= pm_next;
      py_reg  <= py_next;
    end
  end

  assign bus.cnt_day = day_reg;
  assign bus.cnt_mon = mon_reg;
  assign bus.cnt_yr  = yr_reg;
  assign bus.pulse_m = pm_reg;
  assign bus.pulse_y = py_reg;

endmodule

// File: tb/tb_count_date.sv
// tb_count_date: directed test of count_date. Three instances share one
// stimulus stream: dut_a (YEAR_INIT 24), dut_b (YEAR_INIT 99) for the 2099
// wrap, dut_c (YEAR_INIT 23, YEAR_MAX 23) for a non-leap February and a
// reduced year range.
module tb_count_date;
  import clock_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic set_d;
  logic pulse_d;

  count_date_if if_a ();
  count_date_if if_b ();
  count_date_if if_c ();

  assign if_a.pulse_d = pulse_d;
  assign if_b.pulse_d = pulse_d;
  assign if_c.pulse_d = pulse_d;

`ifdef COUNT_DATE_LOAD_EN
  logic             ld_en;
  logic [DAY_W-1:0] ld_day;
  logic [MON_W-1:0] ld_mon;
  logic [YR_W-1:0]  ld_yr;
  assign if_a.ld_en = ld_en;  assign if_a.ld_day = ld_day;
  assign if_a.ld_mon = ld_mon; assign if_a.ld_yr = ld_yr;
  assign if_b.ld_en = ld_en;  assign if_b.ld_day = ld_day;
  assign if_b.ld_mon = ld_mon; assign if_b.ld_yr = ld_yr;
  assign if_c.ld_en = ld_en;  assign if_c.ld_day = ld_day;
  assign if_c.ld_mon = ld_mon; assign if_c.ld_yr = ld_yr;
`endif

  count_date #(.YEAR_INIT(24), .YEAR_MAX(99)) dut_a (.clk(clk), .set_d(set_d), .bus(if_a.slave));
  count_date #(.YEAR_INIT(99), .YEAR_MAX(99)) dut_b (.clk(clk), .set_d(set_d), .bus(if_b.slave));
  count_date #(.YEAR_INIT(23), .YEAR_MAX(23)) dut_c (.clk(clk), .set_d(set_d), .bus(if_c.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int pm_cnt  = 0;
  int py_cnt  = 0;
  bit count_en = 1'b0;

  // Carry pulses of dut_a are tallied once per clock, away from the edge.
  always @(negedge clk) begin
    if (count_en) begin
      pm_cnt = pm_cnt + int'(if_a.pulse_m);
      py_cnt = py_cnt + int'(if_a.pulse_y);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One day carry; on return the registered result is visible.
  task automatic pulse();
    pulse_d = 1'b1;
    step();
    pulse_d = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      pulse();
      step();
    end
  endtask

  initial begin
    set_d   = 1'b1;
    pulse_d = 1'b1;
`ifdef COUNT_DATE_LOAD_EN
    ld_en = 1'b0; ld_day = '0; ld_mon = '0; ld_yr = '0;
`endif
    // Reset dominates a held pulse_d.
    step();
    step();
    set_d   = 1'b0;
    pulse_d = 1'b0;
    check("rst_a_day", 32'(if_a.cnt_day), 1);
    check("rst_a_mon", 32'(if_a.cnt_mon), 1);
    check("rst_a_yr",  32'(if_a.cnt_yr),  24);
    check("rst_a_pm",  32'(if_a.pulse_m), 0);
    check("rst_a_py",  32'(if_a.pulse_y), 0);
    check("rst_b_yr",  32'(if_b.cnt_yr),  99);

    repeat (10) step();
    check("hold_a_day", 32'(if_a.cnt_day), 1);
    check("hold_a_mon", 32'(if_a.cnt_mon), 1);
    check("hold_a_pm",  32'(if_a.pulse_m), 0);

    // Jan 31 2024 -> Feb 1 2024
    pulses(30);
    check("jan31_day", 32'(if_a.cnt_day), 31);
    check("jan31_mon", 32'(if_a.cnt_mon), 1);
    pulse();
    check("feb1_day", 32'(if_a.cnt_day), 1);
    check("feb1_mon", 32'(if_a.cnt_mon), 2);
    check("feb1_pm",  32'(if_a.pulse_m), 1);
    check("feb1_py",  32'(if_a.pulse_y), 0);
    step();
    check("feb1_pm_drop", 32'(if_a.pulse_m), 0);

    // Feb 28: 2024 goes to Feb 29, 2023 jumps to Mar 1
    pulses(27);
    check("a_feb28_day", 32'(if_a.cnt_day), 28);
    check("c_feb28_day", 32'(if_c.cnt_day), 28);
    check("c_feb28_mon", 32'(if_c.cnt_mon), 2);
    pulse();
    check("a_feb29_day", 32'(if_a.cnt_day), 29);
    check("a_feb29_mon", 32'(if_a.cnt_mon), 2);
    check("a_feb29_pm",  32'(if_a.pulse_m), 0);
    check("c_mar1_day",  32'(if_c.cnt_day), 1);
    check("c_mar1_mon",  32'(if_c.cnt_mon), 3);
    check("c_mar1_yr",   32'(if_c.cnt_yr),  23);
    check("c_mar1_pm",   32'(if_c.pulse_m), 1);
    step();
    pulse();
    check("a_mar1_day", 32'(if_a.cnt_day), 1);
    check("a_mar1_mon", 32'(if_a.cnt_mon), 3);
    check("a_mar1_pm",  32'(if_a.pulse_m), 1);
    step();

    // Reset mid-run, coincident with a day pulse.
    set_d = 1'b1;
    step();
    set_d = 1'b0;
    pulses(40);
    check("feb10_day", 32'(if_a.cnt_day), 10);
    check("feb10_mon", 32'(if_a.cnt_mon), 2);
    set_d   = 1'b1;
    pulse_d = 1'b1;
    step();
    set_d   = 1'b0;
    pulse_d = 1'b0;
    check("midrst_day", 32'(if_a.cnt_day), 1);
    check("midrst_mon", 32'(if_a.cnt_mon), 1);
    check("midrst_yr",  32'(if_a.cnt_yr),  24);
    check("midrst_pm",  32'(if_a.pulse_m), 0);
    check("midrst_py",  32'(if_a.pulse_y), 0);
    step();

    // Full leap year on dut_a; year wraps on dut_b and dut_c along the way.
    pm_cnt   = 0;
    py_cnt   = 0;
    count_en = 1'b1;
    pulses(364);
    check("b_dec31_day", 32'(if_b.cnt_day), 31);
    check("b_dec31_mon", 32'(if_b.cnt_mon), 12);
    check("c_dec31_day", 32'(if_c.cnt_day), 31);
    check("c_dec31_mon", 32'(if_c.cnt_mon), 12);
    check("a_dec30_day", 32'(if_a.cnt_day), 30);
    check("a_dec30_mon", 32'(if_a.cnt_mon), 12);
    pulse();
    check("b_wrap_day", 32'(if_b.cnt_day), 1);
    check("b_wrap_mon", 32'(if_b.cnt_mon), 1);
    check("b_wrap_yr",  32'(if_b.cnt_yr),  0);
    check("b_wrap_pm",  32'(if_b.pulse_m), 1);
    check("b_wrap_py",  32'(if_b.pulse_y), 1);
    check("c_wrap_yr",  32'(if_c.cnt_yr),  0);
    check("c_wrap_py",  32'(if_c.pulse_y), 1);
    check("a_dec31_day", 32'(if_a.cnt_day), 31);
    check("a_dec31_pm",  32'(if_a.pulse_m), 0);
    step();
    check("b_wrap_py_drop", 32'(if_b.pulse_y), 0);
    pulse();
    check("a_ny_day", 32'(if_a.cnt_day), 1);
    check("a_ny_mon", 32'(if_a.cnt_mon), 1);
    check("a_ny_yr",  32'(if_a.cnt_yr),  25);
    check("a_ny_pm",  32'(if_a.pulse_m), 1);
    check("a_ny_py",  32'(if_a.pulse_y), 1);
    step();
    check("a_ny_py_drop", 32'(if_a.pulse_y), 0);
    count_en = 1'b0;
    check("year_pm_count", 32'(pm_cnt), 12);
    check("year_py_count", 32'(py_cnt), 1);

`ifdef COUNT_DATE_LOAD_EN
    // Day 31 clamped to April's 30.
    ld_en = 1'b1; ld_day = 5'd31; ld_mon = 4'd4; ld_yr = 7'd23;
    step();
    ld_en = 1'b0;
    check("ld_apr_day", 32'(if_a.cnt_day), 30);
    check("ld_apr_mon", 32'(if_a.cnt_mon), 4);
    check("ld_apr_yr",  32'(if_a.cnt_yr),  23);
    check("ld_apr_pm",  32'(if_a.pulse_m), 0);
    // Illegal month: whole load ignored.
    ld_en = 1'b1; ld_day = 5'd5; ld_mon = 4'd13; ld_yr = 7'd10;
    step();
    ld_en = 1'b0;
    check("ld_bad_day", 32'(if_a.cnt_day), 30);
    check("ld_bad_mon", 32'(if_a.cnt_mon), 4);
    check("ld_bad_yr",  32'(if_a.cnt_yr),  23);
    // Load wins over a coincident pulse; day 0 becomes 1.
    ld_en = 1'b1; ld_day = 5'd0; ld_mon = 4'd2; ld_yr = 7'd24;
    pulse_d = 1'b1;
    step();
    ld_en = 1'b0;
    pulse_d = 1'b0;
    check("ld_pd_day", 32'(if_a.cnt_day), 1);
    check("ld_pd_mon", 32'(if_a.cnt_mon), 2);
    check("ld_pd_yr",  32'(if_a.cnt_yr),  24);
    check("ld_pd_pm",  32'(if_a.pulse_m), 0);
    // Feb 31 clamped to 28 in a non-leap year.
    ld_en = 1'b1; ld_day = 5'd31; ld_mon = 4'd2; ld_yr = 7'd23;
    step();
    ld_en = 1'b0;
    check("ld_feb_day", 32'(if_a.cnt_day), 28);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_date.md
Name: count_date

Overview:
- Calendar stage directly downstream of the hour counter in the digital-clock chain.
- Consumes the one-cycle day-carry pulse (pulse_d) and maintains day-of-month, month and two-digit year (2000–2099).
- Leap-year aware.
- Emits month and year carry pulses for display/alarm logic further downstream.

Parameters:
- YEAR_INIT, 24, year value loaded on reset (0–99, meaning 20xx).
- YEAR_MAX, 99, last year value before wrap to 0.

Ports:
- clk  input  1  system clock, rising edge
- set_d  input  1  reset, synchronous, active-high
- pulse_d  input  1  day-carry from hour counter, one clk wide, qualifies an increment
- cnt_day  output  5  day of month, 1–31
- cnt_mon  output  4  month, 1–12
- cnt_yr  output  7  year offset from 2000, 0–YEAR_MAX
- pulse_m  output  1  registered month-carry, high one cycle on the day→1 rollover
- pulse_y  output  1  registered year-carry, high one cycle on the Dec 31 → Jan 1 rollover

Behaviour:
- All state updates on posedge clk only. Reset is synchronous and active-high.
- set_d=1 overrides everything:
  - cnt_day=1, cnt_mon=1, cnt_yr=YEAR_INIT
  - pulse_m=0, pulse_y=0
- Reset asserted mid-operation discards any pulse_d in the same cycle.
- pulse_d=0: all counters hold; pulse_m=pulse_y=0. Pulses are never stretched.
- pulse_d=1: one-cycle latency; the new date is visible the cycle after the pulse_d edge.
- Days in month (dim):
  - 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - Feb = 29 if cnt_yr[1:0]==0, else 28. This is exact for 2000–2099.
- Increment rules on pulse_d=1:
  - cnt_day<dim: cnt_day+1; pulse_m=0, pulse_y=0.
  - cnt_day==dim and cnt_mon<12: cnt_day=1, cnt_mon+1; pulse_m=1, pulse_y=0.
  - cnt_day==dim and cnt_mon==12: cnt_day=1, cnt_mon=1, pulse_m=1, pulse_y=1. Year increments, wrapping from YEAR_MAX to 0.
- Defensive recovery:
  - If cnt_day>dim (reachable only via load) or cnt_mon is out of 1–12, the next pulse_d applies the rollover branch.
  - An illegal month is forced to 1; year is unchanged in that case, and pulse_y=0.
- No internal FSM beyond the counter cascade. Outputs are registers, not decoded combinationally.

Optional Feature:
- Macro: COUNT_DATE_LOAD_EN.
- Defined: adds ports ld_en (in 1), ld_day (in 5), ld_mon (in 4), ld_yr (in 7).
  - Priority: set_d > ld_en > pulse_d.
  - On ld_en=1 the date is written with validation:
    - ld_mon outside 1–12 → the whole load is ignored (state holds).
    - ld_yr>YEAR_MAX → the whole load is ignored.
    - ld_day=0 → day becomes 1.
    - ld_day>dim(ld_mon, ld_yr) → day is clamped to dim.
  - pulse_m=pulse_y=0 in any load cycle; a coincident pulse_d is dropped.
- Undefined: load ports are absent; the date is changed only by reset and pulse_d.

Decomposition:
- Shared package clock_pkg:
  - Width constants DAY_W=5, MON_W=4, YR_W=7.
  - Month constants MON_JAN..MON_DEC.
  - Constant array of 12 non-leap month lengths.
  - Function is_leap(yr).
- One natural sub-module: days_in_month. Combinational; inputs mon and yr, output 5-bit dim. Instanced once for the running date and, under COUNT_DATE_LOAD_EN, once for load validation.

Test Plan:
- Reset: set_d=1 for 2 cycles with pulse_d=1 → cnt_day=1, cnt_mon=1, cnt_yr=24, pulse_m=pulse_y=0. Hold pulse_d=0 for 10 cycles → no change.
- Month rollover: from Jan 31 2024 pulse_d once → Feb 1 2024, pulse_m=1 for exactly one cycle, pulse_y=0.
- Leap year: Feb 28 2024 → Feb 29 → Mar 1 with pulse_m. From Feb 28 2023, pulse_d → Mar 1 2023 directly.
- Year wrap: Dec 31 99, pulse_d → Jan 1 00, pulse_m=pulse_y=1 for one cycle. Dec 31 24 → Jan 1 25, pulse_y=1.
- Reset mid-run: after 40 pulses from reset (Feb 10 2024), assert set_d coincident with pulse_d → Jan 1 24, no carry pulses. Then 366 pulses → Jan 1 25 with exactly 12 pulse_m and 1 pulse_y.
- COUNT_DATE_LOAD_EN: load day=31, mon=4, yr=23 → Apr 30 23. Load mon=13 → state unchanged. Load coincident with pulse_d → loaded value, no increment.
